// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator and the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, TIMEOUT} pwm_cap_state_t;

  // Number of clk cycles in one nominal PWM period.
  function automatic int cycles_per_period(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Input conditioning for pwm_capture: 2-FF synchronizer, optional glitch filter
// (PWM_CAPTURE_FILTER_EN), then registered level plus rise/fall strobes.
module sync_edge_det #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync0, sync1;
  logic cond;
  logic cond_d;
  logic rise_q, fall_q;

  if (FILTER_LEN < 1) begin : g_filter_len_check
    $error("FILTER_LEN must be at least 1");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= din;
      sync1 <= sync1 == sync0 ? sync1 : sync0;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] stable_cnt;
  logic          filt;

  // The filtered level only follows the synchronizer once it has disagreed for
  // FILTER_LEN consecutive cycles; any shorter excursion resets the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_cnt <= '0;
      filt       <= 1'b0;
    end else if (sync1 != filt) begin
      if (stable_cnt == CW'(FILTER_LEN - 1)) begin
        filt       <= sync1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  assign cond = filt;
`else
  assign cond = sync1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cond_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cond_d <= cond;
      rise_q <= cond & ~cond_d;
      fall_q <= ~cond & cond_d;
    end
  end

  assign level = cond_d;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal, flags a stuck input.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int PWM_FREQ    = 20_000,
  parameter int TIMEOUT_CNT = 2 * cycles_per_period(CLK_FREQ, PWM_FREQ),
  parameter int WL          = $clog2(TIMEOUT_CNT + 1),
  parameter int FILTER_LEN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pwm,
  output logic [WL-1:0] o_period,
  output logic [WL-1:0] o_high,
  output logic          o_valid,
  output logic          o_timeout,
  output logic          o_level
);

  localparam logic [WL-1:0] TMAX = WL'(TIMEOUT_CNT);

  logic           level, rise, fall;
  pwm_cap_state_t state, state_nxt;
  logic [WL-1:0]  per_cnt, high_cnt, high_hold;
  logic           arm, report, latch_high;

  sync_edge_det #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_edge_det (
    .clk   (clk),
    .rst   (rst),
    .din   (i_pwm),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A rise always wins over the timeout check, so a period of exactly
  // TIMEOUT_CNT cycles is still reported.
  always_comb begin
    state_nxt  = state;
    arm        = 1'b0;
    report     = 1'b0;
    latch_high = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          arm       = 1'b1;
        end
      end
      HIGH: begin
        if (rise) begin
          arm    = 1'b1;
          report = 1'b1;
        end else if (fall) begin
          state_nxt  = LOW;
          latch_high = 1'b1;
        end else if (per_cnt == TMAX) begin
          state_nxt = TIMEOUT;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
          arm       = 1'b1;
          report    = 1'b1;
        end else if (per_cnt == TMAX) begin
          state_nxt = TIMEOUT;
        end
      end
      TIMEOUT: begin
        if (rise) begin
          state_nxt = HIGH;
          arm       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt  <= '0;
      high_cnt <= '0;
    end else if (arm) begin
      per_cnt  <= WL'(1);
      high_cnt <= WL'(1);
    end else if (state != IDLE) begin
      if (per_cnt != TMAX)           per_cnt  <= per_cnt + WL'(1);
      if (level && high_cnt != TMAX) high_cnt <= high_cnt + WL'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            high_hold <= '0;
    else if (latch_high) high_hold <= high_cnt;
  end

  // A rise seen while still in HIGH means the fall was lost, so the whole
  // period counts as high time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_level   <= 1'b0;
    end else begin
      o_valid   <= report;
      o_timeout <= (state_nxt == TIMEOUT);
      o_level   <= level;
      if (report) begin
        o_period <= per_cnt;
        o_high   <= (state == HIGH) ? per_cnt : high_hold;
      end
    end
  end

endmodule
